calc_cmd_sched: RTL and testbench

//  Command scheduler in front of the calc core. Buffers keypad codes in a small FIFO.

---
 rtl/calc_pkg.sv | 33 +++
 rtl/cmd_fifo.sv | 60 ++++++
 rtl/calc_cmd_sched.sv | 130 +++++++++++++
 tb/tb_calc_cmd_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared command, status and fault encodings for the calc scheduler and its FIFO.
package calc_pkg;

  localparam logic [3:0] CMD_DIGIT_MAX = 4'd9;
  localparam logic [3:0] CMD_ADD       = 4'd10;
  localparam logic [3:0] CMD_SUB       = 4'd11;
  localparam logic [3:0] CMD_MUL       = 4'd12;
  localparam logic [3:0] CMD_IDLE      = 4'd13;
  localparam logic [3:0] CMD_EQ        = 4'd14;
  localparam logic [3:0] CMD_BKSP      = 4'd15;

  localparam logic [1:0] STAT_ERR   = 2'b00;
  localparam logic [1:0] STAT_BUSY  = 2'b01;
  localparam logic [1:0] STAT_READY = 2'b10;
  localparam logic [1:0] STAT_PRINT = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_CALC    = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef logic [2:0] sched_state_t;
  localparam sched_state_t ST_IDLE       = 3'd0;
  localparam sched_state_t ST_ISSUE      = 3'd1;
  localparam sched_state_t ST_SETTLE     = 3'd2;
  localparam sched_state_t ST_WAIT_READY = 3'd3;
  localparam sched_state_t ST_ERROR      = 3'd4;

  // The idle code is reserved for the bus itself, so it can never be queued.
  function automatic logic is_queueable(input logic [3:0] code);
    return code != CMD_IDLE;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO of 4-bit keypad codes with show-ahead head, flush and level.
module cmd_fifo #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [3:0]    i_data,
  output logic [3:0]    o_head,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop && !o_full)
        r_level <= r_level + LW'(1);
      else if (w_do_pop && !w_do_push)
        r_level <= r_level - LW'(1);
    end
  end

endmodule

// File: rtl/calc_cmd_sched.sv
// Issues queued keypad codes to the calc core one at a time, pacing on calc status
// and latching calc errors or ready timeouts until reset.
module calc_cmd_sched
  import calc_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int HOLD_CYC = 1,
  parameter  int SETTLE   = 2,
  parameter  int TIMEOUT  = 64,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_key_valid,
  input  logic [3:0]    i_key_code,
  output logic          o_key_ready,
  input  logic [1:0]    i_calc_status,
  output logic [3:0]    o_cmd,
  output logic [LW-1:0] o_fifo_level,
  output logic          o_overflow,
  output logic          o_dropped,
  output logic [1:0]    o_fault
);

  localparam int PW = $clog2(HOLD_CYC + SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t  r_state;
  logic [3:0]    r_cmd;
  logic [PW-1:0] r_phase_cnt;
  logic [TW-1:0] r_to_cnt;
  logic [1:0]    r_fault;
  logic          r_overflow;
  logic          r_dropped;

  logic       w_full, w_empty, w_pop, w_push, w_flush;
  logic       w_in_err, w_stat_err, w_ready, w_timeout, w_to_error, w_queueable;
  logic [3:0] w_head;

  assign w_in_err    = (r_state == ST_ERROR);
  assign w_stat_err  = (i_calc_status == STAT_ERR);
  assign w_ready     = (i_calc_status == STAT_READY);
  assign w_queueable = i_key_valid && is_queueable(i_key_code);
  assign w_pop       = (r_state == ST_IDLE) && !w_empty && w_ready;
  assign w_push      = w_queueable && !w_in_err;
  assign w_timeout   = (r_state == ST_WAIT_READY) && !w_ready && (r_to_cnt == TW'(TIMEOUT - 1));
  assign w_to_error  = !w_in_err && (w_stat_err || w_timeout);
  // Flushing on the entry edge too keeps the level at zero for every ERROR cycle.
  assign w_flush     = w_in_err || w_to_error;

  assign o_key_ready = !w_full && !w_in_err;
  assign o_cmd       = r_cmd;
  assign o_fault     = r_fault;
  assign o_overflow  = r_overflow;
  assign o_dropped   = r_dropped;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (i_key_code),
    .o_head  (w_head),
    .o_level (o_fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd       <= CMD_IDLE;
      r_phase_cnt <= '0;
      r_to_cnt    <= '0;
      r_fault     <= FAULT_NONE;
    end else if (w_to_error) begin
      r_state <= ST_ERROR;
      r_cmd   <= CMD_IDLE;
      r_fault <= w_stat_err ? FAULT_CALC : FAULT_TIMEOUT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_cmd       <= w_head;
            r_phase_cnt <= '0;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_phase_cnt == PW'(HOLD_CYC - 1)) begin
            r_cmd       <= CMD_IDLE;
            r_phase_cnt <= '0;
            r_state     <= ST_SETTLE;
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end
        ST_SETTLE: begin
          if (r_phase_cnt == PW'(SETTLE - 1)) begin
            r_to_cnt <= '0;
            r_state  <= ST_WAIT_READY;
          end else begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
          end
        end
        ST_WAIT_READY: begin
          if (w_ready)
            r_state <= ST_IDLE;
          else if (r_to_cnt != TW'(TIMEOUT))
            r_to_cnt <= r_to_cnt + TW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      if (w_queueable && w_full && !w_pop)
        r_overflow <= 1'b1;
      if (i_key_valid && !is_queueable(i_key_code))
        r_dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calc_cmd_sched.sv
// Self-checking bench: timeline-based reference model compared every cycle, plus directed literal checks.
module tb_calc_cmd_sched;
  import calc_pkg::*;

  localparam int DEPTH = 8;
  localparam int HOLD  = 1;
  localparam int SETL  = 2;
  localparam int TO    = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [1:0] status = 2'b10;
  logic       key_ready;
  logic [3:0] cmd;
  logic [3:0] level;
  logic       overflow, dropped;
  logic [1:0] fault;

  int n_cmp = 0;
  int n_bad = 0;
  int issued[$];

  always #5 clk = ~clk;

  calc_cmd_sched #(.DEPTH(DEPTH), .HOLD_CYC(HOLD), .SETTLE(SETL), .TIMEOUT(TO)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_key_valid   (key_valid),
    .i_key_code    (key_code),
    .o_key_ready   (key_ready),
    .i_calc_status (status),
    .o_cmd         (cmd),
    .o_fifo_level  (level),
    .o_overflow    (overflow),
    .o_dropped     (dropped),
    .o_fault       (fault)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of codes and the edge index at which the current code
  // was issued; every phase boundary is derived from that timestamp.
  int q[$];
  bit m_err, m_busy, m_ovf, m_drop;
  int m_fault, m_t, m_code, m_cyc;

  always @(posedge clk) begin : model
    bit pop, to_err, full;
    if (!rst_n) begin
      q.delete();
      m_err = 0; m_busy = 0; m_ovf = 0; m_drop = 0;
      m_fault = 0; m_t = 0; m_code = 13; m_cyc = 0;
    end else begin
      pop = 0; to_err = 0;
      full = (q.size() == DEPTH);
      m_cyc++;
      if (!m_err) begin
        if (status == 2'b00) begin
          to_err = 1; m_fault = 1;
        end else if (m_busy) begin
          if (m_cyc > m_t + HOLD + SETL) begin
            if (status == 2'b10) m_busy = 0;
            else if (m_cyc == m_t + HOLD + SETL + TO) begin
              to_err = 1; m_fault = 2;
            end
          end
        end else if (q.size() > 0 && status == 2'b10) begin
          pop = 1; m_code = q.pop_front(); m_busy = 1; m_t = m_cyc;
        end
      end
      if (key_valid && key_code == 4'd13) m_drop = 1;
      else if (key_valid && !m_err) begin
        if (!full || pop) q.push_back(int'(key_code));
        else m_ovf = 1;
      end
      if (to_err) begin
        m_err = 1; m_busy = 0; q.delete();
      end
    end
  end

  always @(negedge clk) begin : compare
    int exp_cmd;
    if (rst_n) begin
      exp_cmd = (!m_err && m_busy && m_cyc < m_t + HOLD) ? m_code : 13;
      chk("cmd", int'(cmd), exp_cmd);
      chk("level", int'(level), q.size());
      chk("key_ready", int'(key_ready), int'(!m_err && q.size() < DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("dropped", int'(dropped), int'(m_drop));
      chk("fault", int'(fault), m_fault);
      if (cmd != 4'd13) issued.push_back(int'(cmd));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; key_valid = 1'b0; status = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic [1:0] s);
    @(negedge clk);
    key_valid = v; key_code = c; status = s;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int seq[5] = '{1, 2, 10, 3, 14};
    int hold;
    int r;

    // Single key: issued one edge after acceptance, held one cycle.
    do_reset();
    chk("rst_cmd", int'(cmd), 13);
    chk("rst_level", int'(level), 0);
    chk("rst_fault", int'(fault), 0);
    step(1'b1, 4'd5, 2'b10); after_edge();
    chk("k5_level_k", int'(level), 1);
    chk("k5_cmd_k", int'(cmd), 13);
    step(1'b0, 4'd0, 2'b10); after_edge();
    chk("k5_cmd_k1", int'(cmd), 5);
    chk("k5_level_k1", int'(level), 0);
    step(1'b0, 4'd0, 2'b10); after_edge();
    chk("k5_cmd_k2", int'(cmd), 13);
    $display("scenario single-key done");

    // Burst with calc printing for 9 cycles after every code.
    do_reset();
    issued.delete();
    hold = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (cmd != 4'd13) hold = 9;
      status = (hold > 0) ? 2'b11 : 2'b10;
      if (hold > 0) hold--;
      key_valid = (i < 5);
      key_code  = (i < 5) ? 4'(seq[i]) : 4'd0;
    end
    chk("burst_count", issued.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("burst_order", (issued.size() > i) ? issued[i] : -1, seq[i]);
    $display("scenario burst done");

    // Fill past full with calc busy.
    do_reset();
    issued.delete();
    for (int i = 0; i < 9; i++) step(1'b1, 4'(i), 2'b01);
    step(1'b0, 4'd0, 2'b01); after_edge();
    chk("ovf_level", int'(level), 8);
    chk("ovf_key_ready", int'(key_ready), 0);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_no_issue", issued.size(), 0);
    $display("scenario overflow done");

    // Ready timeout after an issue.
    do_reset();
    step(1'b1, 4'd7, 2'b10);
    step(1'b0, 4'd0, 2'b10);
    step(1'b1, 4'd3, 2'b01);
    step(1'b1, 4'd4, 2'b01);
    repeat (64) step(1'b0, 4'd0, 2'b01);
    after_edge();
    chk("to_fault_before", int'(fault), 0);
    chk("to_level_before", int'(level), 2);
    step(1'b0, 4'd0, 2'b01); after_edge();
    chk("to_fault", int'(fault), 2);
    chk("to_cmd", int'(cmd), 13);
    chk("to_level", int'(level), 0);
    chk("to_key_ready", int'(key_ready), 0);
    $display("scenario timeout done");

    // Calc error while the code is on the bus.
    do_reset();
    step(1'b1, 4'd6, 2'b10);
    step(1'b0, 4'd0, 2'b10); after_edge();
    chk("err_cmd_hold", int'(cmd), 6);
    step(1'b0, 4'd0, 2'b00); after_edge();
    chk("err_fault", int'(fault), 1);
    chk("err_cmd", int'(cmd), 13);
    step(1'b1, 4'd2, 2'b10);
    step(1'b1, 4'd3, 2'b10); after_edge();
    chk("err_level", int'(level), 0);
    chk("err_fault_sticky", int'(fault), 1);
    $display("scenario calc-error done");

    // Idle code dropped, then asynchronous reset while issuing.
    do_reset();
    step(1'b1, 4'd13, 2'b10); after_edge();
    chk("drop_flag", int'(dropped), 1);
    chk("drop_level", int'(level), 0);
    step(1'b1, 4'd8, 2'b01);
    step(1'b1, 4'd9, 2'b10); after_edge();
    chk("mid_cmd", int'(cmd), 8);
    chk("mid_level", int'(level), 1);
    #1 rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    chk("arst_cmd", int'(cmd), 13);
    chk("arst_level", int'(level), 0);
    chk("arst_dropped", int'(dropped), 0);
    chk("arst_fault", int'(fault), 0);
    chk("arst_key_ready", int'(key_ready), 1);
    do_reset();
    $display("scenario reset-mid-issue done");

    // Random traffic without calc errors.
    do_reset();
    repeat (600) begin
      r = $urandom_range(7);
      step(1'($urandom_range(2) == 0), 4'($urandom_range(15)),
           (r < 4) ? 2'b10 : (r < 6) ? 2'b11 : 2'b01);
    end
    $display("scenario random done");

    // Random traffic with rare calc errors.
    do_reset();
    repeat (300) begin
      r = $urandom_range(199);
      step(1'($urandom_range(1)), 4'($urandom_range(15)),
           (r == 0) ? 2'b00 : (r < 120) ? 2'b10 : (r < 160) ? 2'b11 : 2'b01);
    end
    $display("scenario random-error done");

    step(1'b0, 4'd0, 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
